// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds the FSM state encoding, the result codes and the chunk-count helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  function automatic int nchunk(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_chunk.sv
// Combinational DIGIT-bit magnitude compare of one chunk.
// inv_sign flips the chunk MSB so a two's-complement sign chunk orders correctly.
module cmp_chunk #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             inv_sign,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] flip;
  logic [DIGIT-1:0] a_m;
  logic [DIGIT-1:0] b_m;

  assign flip = DIGIT'(inv_sign) << (DIGIT - 1);
  assign a_m  = a ^ flip;
  assign b_m  = b ^ flip;
  assign gt   = a_m > b_m;
  assign lt   = a_m < b_m;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first, DIGIT bits per
// cycle, and presents eq/gt/lt plus the number of RUN cycles used.
//
//   state | meaning
//   IDLE  | ready for operands (once out of reset)
//   RUN   | comparing one chunk per edge
//   DONE  | result valid, held until out_ready
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  x,
  input  logic [WIDTH-1:0]                  y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              eq,
  output logic                              gt,
  output logic                              lt,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]  cycles
);

  localparam int NCHUNK = nchunk(WIDTH, DIGIT);
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CYW    = $clog2(NCHUNK + 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic             armed;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CNTW-1:0]  cnt;
  logic [1:0]       res;
  logic [CYW-1:0]   cyc;
  logic             chunk_gt;
  logic             chunk_lt;
  logic             first;
  logic             last;
  logic             decide_now;
  logic             finish;
  logic             accept;

  assign first      = (cnt == '0);
  assign last       = (cnt == CNTW'(NCHUNK - 1));
  assign decide_now = (res == CMP_EQ) && (chunk_gt || chunk_lt);
  assign finish     = last || ((EARLY_EXIT != 0) && decide_now);
  assign accept     = in_valid && in_ready;

  cmp_chunk #(.DIGIT(DIGIT)) u_chunk (
    .a        (sh_a[WIDTH-1 -: DIGIT]),
    .b        (sh_b[WIDTH-1 -: DIGIT]),
    .inv_sign ((SIGNED != 0) && first),
    .gt       (chunk_gt),
    .lt       (chunk_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      res   <= CMP_EQ;
      cyc   <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            sh_a <= x;
            sh_b <= y;
            cnt  <= '0;
            res  <= CMP_EQ;
          end
        end
        RUN: begin
          if (decide_now) res <= chunk_gt ? CMP_GT : CMP_LT;
          sh_a <= sh_a << DIGIT;
          sh_b <= sh_b << DIGIT;
          cnt  <= cnt + 1'b1;
          if (finish) cyc <= CYW'(cnt) + CYW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = (state == DONE);
  assign eq        = out_valid && (res == CMP_EQ);
  assign gt        = out_valid && (res == CMP_GT);
  assign lt        = out_valid && (res == CMP_LT);
  assign cycles    = cyc;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator across four parameter sets
// sharing one handshake: unsigned/early-exit, no early-exit, signed, and NCHUNK=1.
module tb_seq_magnitude_comparator;

  localparam logic [1:0] R_EQ = 2'd0;
  localparam logic [1:0] R_GT = 2'd1;
  localparam logic [1:0] R_LT = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] x, y;
  logic [3:0] x1, y1;

  logic       ir_a, ov_a, eq_a, gt_a, lt_a;
  logic [2:0] cy_a;
  logic       ir_b, ov_b, eq_b, gt_b, lt_b;
  logic [2:0] cy_b;
  logic       ir_c, ov_c, eq_c, gt_c, lt_c;
  logic [2:0] cy_c;
  logic       ir_d, ov_d, eq_d, gt_d, lt_d;
  logic [0:0] cy_d;

  int checks = 0;
  int errors = 0;
  int lat_a, lat_b, lat_c, lat_d;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0), .EARLY_EXIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .x(x), .y(y),
    .out_valid(ov_a), .out_ready(out_ready), .eq(eq_a), .gt(gt_a), .lt(lt_a), .cycles(cy_a));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0), .EARLY_EXIT(0)) u_noee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .x(x), .y(y),
    .out_valid(ov_b), .out_ready(out_ready), .eq(eq_b), .gt(gt_b), .lt(lt_b), .cycles(cy_b));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1), .EARLY_EXIT(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .x(x), .y(y),
    .out_valid(ov_c), .out_ready(out_ready), .eq(eq_c), .gt(gt_c), .lt(lt_c), .cycles(cy_c));

  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(4), .SIGNED(1), .EARLY_EXIT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_d), .x(x1), .y(y1),
    .out_valid(ov_d), .out_ready(out_ready), .eq(eq_d), .gt(gt_d), .lt(lt_d), .cycles(cy_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input logic e, input logic g,
                           input logic l, input logic [31:0] cyc, input int lat,
                           input logic [1:0] res, input int exp_lat);
    check({tag, "_valid"}, v, 1'b1);
    check({tag, "_eq"}, e, res == R_EQ);
    check({tag, "_gt"}, g, res == R_GT);
    check({tag, "_lt"}, l, res == R_LT);
    check({tag, "_cycles"}, cyc, exp_lat);
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  // Launch one operand set into all four instances and record per-instance latency.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] a1, input logic [3:0] b1);
    x = a; y = b; x1 = a1; y1 = b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat_a = 0; lat_b = 0; lat_c = 0; lat_d = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ov_a && lat_a == 0) lat_a = i;
      if (ov_b && lat_b == 0) lat_b = i;
      if (ov_c && lat_c == 0) lat_c = i;
      if (ov_d && lat_d == 0) lat_d = i;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, ov_a, 1'b0);
    check({tag, "_rel_ready"}, ir_a, 1'b1);
    tick();
  endtask

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 4; k++)
      if (a[7-2*k -: 2] != b[7-2*k -: 2]) return k + 1;
    return 4;
  endfunction

  function automatic logic [1:0] ref_res(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return R_GT;
    if (a < b) return R_LT;
    return R_EQ;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; x1 = '0; y1 = '0;

    // reset state
    tick(); tick();
    check("rst_in_ready", ir_a, 1'b0);
    check("rst_out_valid", ov_a, 1'b0);
    check("rst_cycles", cy_a, 3'd0);
    check("rst_eq", eq_a, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", ir_a, 1'b1);
    check("post_rst_ready_one", ir_d, 1'b1);

    // equal operands: full scan everywhere
    run_op(8'h5A, 8'h5A, 4'hA, 4'hA);
    check_res("eq_dut", ov_a, eq_a, gt_a, lt_a, cy_a, lat_a, R_EQ, 4);
    check_res("eq_noee", ov_b, eq_b, gt_b, lt_b, cy_b, lat_b, R_EQ, 4);
    check_res("eq_sgn", ov_c, eq_c, gt_c, lt_c, cy_c, lat_c, R_EQ, 4);
    check_res("eq_one", ov_d, eq_d, gt_d, lt_d, cy_d, lat_d, R_EQ, 1);
    release_result("eq");

    // differs at chunk 0: early exit vs full scan; signed sees -64 < 63
    run_op(8'hC0, 8'h3F, 4'h8, 4'h7);
    check_res("c0_dut", ov_a, eq_a, gt_a, lt_a, cy_a, lat_a, R_GT, 1);
    check_res("c0_noee", ov_b, eq_b, gt_b, lt_b, cy_b, lat_b, R_GT, 4);
    check_res("c0_sgn", ov_c, eq_c, gt_c, lt_c, cy_c, lat_c, R_LT, 1);
    check_res("c0_one", ov_d, eq_d, gt_d, lt_d, cy_d, lat_d, R_LT, 1);

    // hold result 10 cycles with stray in_valid pulses
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x = 8'h00; y = 8'hFF;
      tick();
      check("hold_valid", ov_a, 1'b1);
      check("hold_gt", gt_a, 1'b1);
      check("hold_cycles", cy_a, 3'd1);
      check("hold_ready", ir_a, 1'b0);
    end
    in_valid = 1'b0;
    release_result("hold");

    // -128 vs 1: signed lt, unsigned gt
    run_op(8'h80, 8'h01, 4'h7, 4'h8);
    check_res("sg_dut", ov_a, eq_a, gt_a, lt_a, cy_a, lat_a, R_GT, 1);
    check_res("sg_noee", ov_b, eq_b, gt_b, lt_b, cy_b, lat_b, R_GT, 4);
    check_res("sg_sgn", ov_c, eq_c, gt_c, lt_c, cy_c, lat_c, R_LT, 1);
    check_res("sg_one", ov_d, eq_d, gt_d, lt_d, cy_d, lat_d, R_GT, 1);
    release_result("sg");

    // decided at chunk 1, later chunk disagrees and must not override
    run_op(8'h10, 8'h0F, 4'h3, 4'h3);
    check_res("k1_dut", ov_a, eq_a, gt_a, lt_a, cy_a, lat_a, R_GT, 2);
    check_res("k1_noee", ov_b, eq_b, gt_b, lt_b, cy_b, lat_b, R_GT, 4);
    check_res("k1_sgn", ov_c, eq_c, gt_c, lt_c, cy_c, lat_c, R_GT, 2);
    release_result("k1");

    // differs only at the last chunk
    run_op(8'h5B, 8'h5A, 4'h3, 4'h5);
    check_res("last_dut", ov_a, eq_a, gt_a, lt_a, cy_a, lat_a, R_GT, 4);
    check_res("last_sgn", ov_c, eq_c, gt_c, lt_c, cy_c, lat_c, R_GT, 4);
    check_res("last_one", ov_d, eq_d, gt_d, lt_d, cy_d, lat_d, R_LT, 1);

    // reset while a result is presented
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", ov_a, 1'b0);
    check("rst_done_gt", gt_a, 1'b0);
    check("rst_done_cycles", cy_a, 3'd0);
    check("rst_done_ready", ir_a, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_done_rel_ready", ir_a, 1'b1);

    // reset two cycles into RUN
    x = 8'h5A; y = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("rst_run_valid", ov_a, 1'b0);
    check("rst_run_eq", eq_a, 1'b0);
    check("rst_run_ready", ir_a, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rst_run_no_stale", ov_a, 1'b0);
    end
    check("rst_run_rel_ready", ir_a, 1'b1);

    // back-to-back with continuous in_valid/out_ready
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      x = ra; y = rb;
      n = 0;
      while (!ir_a && n < 10) begin tick(); n++; end
      check("b2b_ready", ir_a, 1'b1);
      tick();
      n = 0;
      while (!ov_a && n < 8) begin tick(); n++; end
      check_res("b2b", ov_a, eq_a, gt_a, lt_a, cy_a, n, ref_res(ra, rb), ref_lat(ra, rb));
      tick();
      check("b2b_idle_valid", ov_a, 1'b0);
      check("b2b_idle_ready", ir_a, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-bit, multi-cycle magnitude comparator. It succeeds the 1-bit combinational comparator and is parametrised in operand width, digit size and signedness. Operands are accepted over a valid/ready handshake and scanned MSB-first, DIGIT bits per cycle. An eq/gt/lt result is presented over an output valid/ready handshake. It sits between operand producers and the control datapath, for example for sort, max and threshold checks.

Parameters:
WIDTH, 8, operand width in bits; must be ≥1 and a multiple of DIGIT.
DIGIT, 2, bits compared per cycle; NCHUNK = WIDTH/DIGIT.
SIGNED, 0, 1 = two's-complement compare; 0 = unsigned.
EARLY_EXIT, 1, 1 = finish as soon as a differing chunk is found; 0 = always take NCHUNK cycles.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands x, y are valid.
in_ready  out  1  block can accept operands.
x  in  WIDTH  operand A.
y  in  WIDTH  operand B.
out_valid  out  1  result is valid.
out_ready  in  1  consumer accepts the result.
eq  out  1  x == y.
gt  out  1  x > y.
lt  out  1  x < y.
cycles  out  $clog2(NCHUNK+1)  number of RUN cycles used for this result.

Behaviour:
- rst_n low, asynchronous:
  - state=IDLE; in_ready=0 while rst_n is low, 1 on the first cycle after release.
  - out_valid, eq, gt, lt = 0; cycles = 0; chunk counter = 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No result is produced.
- IDLE:
  - in_ready=1.
  - Edge with in_valid=1: latch x, y into shift registers, clear the decided flag, counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge compares the current top DIGIT bits of A and B (chunk k, MSB-first).
  - For chunk 0 with SIGNED=1, the sign bit of each operand is inverted before the compare.
  - If not yet decided and the chunks differ: record gt/lt, set decided.
  - Shift both registers left by DIGIT; counter++.
  - Go to DONE when counter reaches NCHUNK-1 on this edge, or when EARLY_EXIT=1 and a decision was just made.
- DONE:
  - out_valid=1; eq = !decided.
  - eq, gt, lt, cycles are held stable until out_ready=1.
  - Edge with out_ready=1: out_valid=0, go to IDLE.
  - No same-cycle accept of new operands in DONE; the next accept is earliest one cycle later in IDLE.
- Latency, counted from the accept edge to out_valid high:
  - Equal operands, or EARLY_EXIT=0: NCHUNK edges.
  - Decided at chunk k with EARLY_EXIT=1: k+1 edges.
  - cycles reports this value.
- Exactly one of eq/gt/lt is 1 whenever out_valid=1. All three are 0 whenever out_valid=0.
- in_valid and operands are ignored while in_ready=0. The producer must hold them stable until it sees in_ready.
- NCHUNK=1 is legal: single-cycle RUN.

Decomposition:
- Package cmp_pkg:
  - state enum IDLE/RUN/DONE (2-bit).
  - result encoding constants CMP_EQ/CMP_GT/CMP_LT.
  - function nchunk(WIDTH, DIGIT).
- Sub-module cmp_chunk: combinational DIGIT-bit compare with a sign-invert input, giving gt/lt outputs. It is instanced once.
- The top level holds the FSM, shift registers, counter and result registers.
- Elaboration-time assertion: WIDTH % DIGIT == 0.

Test Plan:
1. WIDTH=8, DIGIT=2, unsigned, x=8'h5A, y=8'h5A → out_valid after 4 edges; eq=1, gt=lt=0, cycles=4.
2. x=8'hC0, y=8'h3F, EARLY_EXIT=1 → gt=1 after 1 edge, cycles=1. Same operands with EARLY_EXIT=0 → gt=1, cycles=4.
3. SIGNED=1, x=8'h80 (−128), y=8'h01 → lt=1. Same operands with SIGNED=0 → gt=1.
4. out_ready held low 10 cycles in DONE → eq/gt/lt/cycles stable and in_ready=0 throughout. in_valid pulses with new operands are ignored.
5. rst_n pulsed low 2 cycles into RUN → out_valid, eq, gt, lt go to 0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.
6. Back-to-back: 16 random operand pairs with out_ready=1 and in_valid=1 continuously → results match a reference model; each result is followed by ≥1 IDLE cycle before the next accept.
